// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 16-bit CPU: opcodes, instruction field slices,
// control state encoding and the strobe bundle. HALT state exists only with CTRL_HALT_EN.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_BF   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM
`ifdef CTRL_HALT_EN
        , ST_HALT
`endif
    } state_e;

    typedef struct packed {
        logic memory_read;
        logic memory_write;
        logic pc_increment;
        logic pc_load;
        logic cmp_compare;
        logic lu_passthrough;
        logic lu_add;
        logic lu_sub;
        logic lu_shr;
        logic lu_shl;
        logic lu_band;
        logic lu_bor;
        logic lu_bxor;
        logic lu_bnegate;
        logic reg1_read;
        logic reg2_read;
        logic reg3_write;
    } ctrl_t;

    function automatic logic [FIELD_W-1:0] op_of(input logic [15:0] ir);
        return ir[OP_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] rd_of(input logic [15:0] ir);
        return ir[RD_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] rs1_of(input logic [15:0] ir);
        return ir[RS1_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] rs2_of(input logic [15:0] ir);
        return ir[RS2_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode from control state, latched opcode, selected flag and
// memory handshake. Opcode F behaviour depends on CTRL_HALT_EN.
module control_decode
    import cpu_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] op,
    input  logic       f_bit,
    input  logic       mem_ready,
    input  logic       wait_hit,
    output ctrl_t      ctrl
);

    logic take_jump;

    assign take_jump = (op == OP_JMP) || ((op == OP_BF) && f_bit);

    always_comb begin
        // NOTE: default every output first so no path through the cases infers a latch.
        ctrl = '0;
        case (state)
            ST_EXEC: begin
                case (op)
                    OP_NOP: ctrl.pc_increment = 1'b1;
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR, OP_XOR: begin
                        ctrl.reg1_read    = 1'b1;
                        ctrl.reg2_read    = 1'b1;
                        ctrl.reg3_write   = 1'b1;
                        ctrl.pc_increment = 1'b1;
                        case (op)
                            OP_ADD:  ctrl.lu_add  = 1'b1;
                            OP_SUB:  ctrl.lu_sub  = 1'b1;
                            OP_SHR:  ctrl.lu_shr  = 1'b1;
                            OP_SHL:  ctrl.lu_shl  = 1'b1;
                            OP_AND:  ctrl.lu_band = 1'b1;
                            OP_OR:   ctrl.lu_bor  = 1'b1;
                            default: ctrl.lu_bxor = 1'b1;
                        endcase
                    end
                    OP_NOT, OP_MOV: begin
                        ctrl.reg1_read      = 1'b1;
                        ctrl.reg3_write     = 1'b1;
                        ctrl.pc_increment   = 1'b1;
                        ctrl.lu_bnegate     = (op == OP_NOT);
                        ctrl.lu_passthrough = (op == OP_MOV);
                    end
                    // Loads and stores present their address only once in MEM.
                    OP_LD, OP_ST: ctrl = '0;
                    OP_CMP: begin
                        ctrl.cmp_compare  = 1'b1;
                        ctrl.reg1_read    = 1'b1;
                        ctrl.reg2_read    = 1'b1;
                        ctrl.pc_increment = 1'b1;
                    end
                    OP_JMP, OP_BF: begin
                        ctrl.reg1_read      = take_jump;
                        ctrl.lu_passthrough = take_jump;
                        ctrl.pc_load        = take_jump;
                        ctrl.pc_increment   = !take_jump;
                    end
                    OP_HALT: begin
`ifdef CTRL_HALT_EN
                        ctrl = '0;
`else
                        ctrl.pc_increment = 1'b1;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                // A ready in the final wait cycle still completes the access.
                if (mem_ready || !wait_hit) begin
                    ctrl.reg2_read = 1'b1;
                    if (op == OP_LD) begin
                        ctrl.memory_read = 1'b1;
                        ctrl.reg3_write  = mem_ready;
                    end else begin
                        ctrl.memory_write   = 1'b1;
                        ctrl.reg1_read      = 1'b1;
                        ctrl.lu_passthrough = 1'b1;
                    end
                end
                ctrl.pc_increment = mem_ready || wait_hit;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/EXEC/MEM sequencer driving all datapath strobes, with a bounded
// memory wait and sticky fault. Define CTRL_HALT_EN to make opcode F a permanent HALT.
module control_unit
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_bus,
    input  logic [15:0] f_bus,
    input  logic        mem_ready,
    output logic        memory_read,
    output logic        memory_write,
    output logic        pc_increment,
    output logic        pc_load,
    output logic        cmp_load,
    output logic        cmp_compare,
    output logic        lu_passthrough,
    output logic        lu_add,
    output logic        lu_sub,
    output logic        lu_shr,
    output logic        lu_shl,
    output logic        lu_band,
    output logic        lu_bor,
    output logic        lu_bxor,
    output logic        lu_bnegate,
    output logic        reg1_read,
    output logic        reg2_read,
    output logic        reg3_write,
    output logic [3:0]  reg1_addr,
    output logic [3:0]  reg2_addr,
    output logic [3:0]  reg3_addr,
    output logic        mem_fault
`ifdef CTRL_HALT_EN
    ,
    output logic        halted
`endif
);

    localparam int WAIT_W = ($clog2(WAIT_LIMIT + 1) > 4) ? $clog2(WAIT_LIMIT + 1) : 4;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

    state_e            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_fault_q, mem_fault_d;
    logic              wait_hit;
    logic [3:0]        op;
    ctrl_t             ctrl;

    assign op       = op_of(ir_q);
    assign wait_hit = (wait_cnt_q == WAIT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            ir_q        <= '0;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state_q     <= state_d;
            ir_q        <= ir_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = i_bus;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if ((op == OP_LD) || (op == OP_ST)) begin
                    state_d    = ST_MEM;
                    wait_cnt_d = '0;
`ifdef CTRL_HALT_EN
                end else if (op == OP_HALT) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (wait_hit) begin
                    state_d     = ST_FETCH;
                    mem_fault_d = 1'b1;
                end else if (wait_cnt_q != {WAIT_W{1'b1}}) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
`ifdef CTRL_HALT_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    control_decode u_decode (
        .state     (state_q),
        .op        (op),
        .f_bit     (f_bus[rd_of(ir_q)]),
        .mem_ready (mem_ready),
        .wait_hit  (wait_hit),
        .ctrl      (ctrl)
    );

    assign memory_read    = ctrl.memory_read;
    assign memory_write   = ctrl.memory_write;
    assign pc_increment   = ctrl.pc_increment;
    assign pc_load        = ctrl.pc_load;
    assign cmp_load       = 1'b0;
    assign cmp_compare    = ctrl.cmp_compare;
    assign lu_passthrough = ctrl.lu_passthrough;
    assign lu_add         = ctrl.lu_add;
    assign lu_sub         = ctrl.lu_sub;
    assign lu_shr         = ctrl.lu_shr;
    assign lu_shl         = ctrl.lu_shl;
    assign lu_band        = ctrl.lu_band;
    assign lu_bor         = ctrl.lu_bor;
    assign lu_bxor        = ctrl.lu_bxor;
    assign lu_bnegate     = ctrl.lu_bnegate;
    assign reg1_read      = ctrl.reg1_read;
    assign reg2_read      = ctrl.reg2_read;
    assign reg3_write     = ctrl.reg3_write;
    assign reg1_addr      = rs1_of(ir_q);
    assign reg2_addr      = rs2_of(ir_q);
    assign reg3_addr      = rd_of(ir_q);
    assign mem_fault      = mem_fault_q;
`ifdef CTRL_HALT_EN
    assign halted         = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed ISA cases, mid-access reset and a
// randomized instruction stream checked against an ISA-level expectation model.
module tb_control_unit;

    localparam int WL = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_bus = '0;
    logic [15:0] f_bus = '0;
    logic        mem_ready = 1'b0;
    logic memory_read, memory_write, pc_increment, pc_load, cmp_load, cmp_compare;
    logic lu_passthrough, lu_add, lu_sub, lu_shr, lu_shl, lu_band, lu_bor, lu_bxor, lu_bnegate;
    logic reg1_read, reg2_read, reg3_write, mem_fault;
    logic [3:0] reg1_addr, reg2_addr, reg3_addr;
`ifdef CTRL_HALT_EN
    logic halted;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic fault_exp = 1'b0;

    control_unit #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .i_bus(i_bus), .f_bus(f_bus), .mem_ready(mem_ready),
        .memory_read(memory_read), .memory_write(memory_write),
        .pc_increment(pc_increment), .pc_load(pc_load),
        .cmp_load(cmp_load), .cmp_compare(cmp_compare),
        .lu_passthrough(lu_passthrough), .lu_add(lu_add), .lu_sub(lu_sub),
        .lu_shr(lu_shr), .lu_shl(lu_shl), .lu_band(lu_band), .lu_bor(lu_bor),
        .lu_bxor(lu_bxor), .lu_bnegate(lu_bnegate),
        .reg1_read(reg1_read), .reg2_read(reg2_read), .reg3_write(reg3_write),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg3_addr(reg3_addr),
        .mem_fault(mem_fault)
`ifdef CTRL_HALT_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    // Strobe vector layout: {mr, mw, pc_inc, pc_load, cmp_load, cmp_cmp, lu[0..8], r1, r2, w3}
    logic [17:0] obs;
    assign obs = {memory_read, memory_write, pc_increment, pc_load, cmp_load, cmp_compare,
                  lu_passthrough, lu_add, lu_sub, lu_shr, lu_shl, lu_band, lu_bor, lu_bxor,
                  lu_bnegate, reg1_read, reg2_read, reg3_write};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // lu: -1 none, 0 passthrough, 1..7 add..bxor, 8 negate.
    function automatic logic [17:0] mk(input bit mr, input bit mw, input bit pi, input bit pl,
                                       input bit cc, input int lu, input bit r1, input bit r2,
                                       input bit w3);
        logic [17:0] v;
        v = '0;
        v[17] = mr; v[16] = mw; v[15] = pi; v[14] = pl; v[12] = cc;
        if (lu >= 0) v[11 - lu] = 1'b1;
        v[2] = r1; v[1] = r2; v[0] = w3;
        return v;
    endfunction

    // ISA semantics of the execute cycle, phrased by what each instruction does.
    function automatic logic [17:0] exp_exec(input logic [15:0] w, input logic [15:0] fv);
        int  op;
        bit  binary, unary, writes, redirect, is_mem, stops;
        int  lu;
        op       = int'(w[15:12]);
        binary   = (op >= 1 && op <= 7);
        unary    = (op == 8 || op == 9);
        writes   = binary || unary;
        redirect = (op == 13) || (op == 14 && fv[w[11:8]]);
        is_mem   = (op == 10 || op == 11);
`ifdef CTRL_HALT_EN
        stops = (op == 15);
`else
        stops = 1'b0;
`endif
        if (is_mem || stops) return '0;
        lu = -1;
        if (binary || op == 8) lu = op;
        if (op == 9 || redirect) lu = 0;
        return mk(0, 0, !redirect, redirect, op == 12, lu,
                  writes || op == 12 || redirect, binary || op == 12, writes);
    endfunction

    // Memory phase k (0-based) with ready arriving at phase n_ready.
    function automatic logic [17:0] exp_mem(input bit is_ld, input int k, input int n_ready);
        bit done, timeout;
        done    = (k == n_ready);
        timeout = (k == WL) && !done;
        if (timeout) return mk(0, 0, 1, 0, 0, -1, 0, 0, 0);
        if (is_ld) return mk(1, 0, done, 0, 0, -1, 0, 1, done);
        return mk(0, 1, done, 0, 0, 0, 1, 1, 0);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from its FETCH cycle; leaves the bench at the next FETCH cycle.
    task automatic run_instr(input logic [15:0] w, input int n_ready, input logic [15:0] fv);
        bit is_mem;
        is_mem = (w[15:12] == 4'hA) || (w[15:12] == 4'hB);
        i_bus = w; f_bus = 16'($urandom); mem_ready = 1'($urandom);
        #1;
        check("fetch_strobes", 32'(obs), 32'(0));
        check("fetch_fault", 32'(mem_fault), 32'(fault_exp));
        next_cycle();
        i_bus = 16'($urandom); f_bus = fv; mem_ready = is_mem ? 1'b0 : 1'($urandom);
        #1;
        check("exec_addr", {20'd0, reg3_addr, reg1_addr, reg2_addr}, {20'd0, w[11:0]});
        check("exec_strobes", 32'(obs), 32'(exp_exec(w, fv)));
        check("exec_fault", 32'(mem_fault), 32'(fault_exp));
`ifdef CTRL_HALT_EN
        check("exec_halted", 32'(halted), 32'(0));
`endif
        next_cycle();
        if (is_mem) begin
            for (int k = 0; k <= WL; k++) begin
                i_bus = 16'($urandom); f_bus = 16'($urandom); mem_ready = (k == n_ready);
                #1;
                check("mem_strobes", 32'(obs), 32'(exp_mem(w[15:12] == 4'hA, k, n_ready)));
                check("mem_fault_hold", 32'(mem_fault), 32'(fault_exp));
                next_cycle();
                if (k == n_ready) break;
                if (k == WL) fault_exp = 1'b1;
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", 32'(obs), 32'(0));
        check("reset_addr", {20'd0, reg3_addr, reg1_addr, reg2_addr}, 32'(0));
        check("reset_fault", 32'(mem_fault), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD r2 <= r3 + r4.
        run_instr(16'h1234, 0, 16'h0000);
        // LD with ready two cycles after MEM entry.
        run_instr(16'hA105, 2, 16'h0000);
        // ST that never sees ready: timeout and sticky fault.
        run_instr(16'hB312, WL + 1, 16'h0000);
        check("fault_sticky", 32'(mem_fault), 32'(1));
        // BF on flag 5, taken then not taken.
        run_instr(16'hE520, 0, 16'h0020);
        run_instr(16'hE520, 0, 16'hFFDF);
        // CMP, NOT, MOV, JMP, NOP.
        run_instr(16'hC012, 0, 16'h0000);
        run_instr(16'h8A70, 0, 16'h0000);
        run_instr(16'h9B60, 0, 16'h0000);
        run_instr(16'hD090, 0, 16'h0000);
        run_instr(16'h0000, 0, 16'hFFFF);

        // Reset asserted mid-LD MEM drops strobes at once and clears the fault.
        i_bus = 16'hA105; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        check("pre_reset_mem", 32'(obs), 32'(exp_mem(1'b1, 0, WL + 1)));
        rst_n = 1'b0;
        #1;
        check("async_reset_strobes", 32'(obs), 32'(0));
        check("async_reset_fault", 32'(mem_fault), 32'(0));
        fault_exp = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("post_reset_addr", {20'd0, reg3_addr, reg1_addr, reg2_addr}, 32'(0));
        check("post_reset_strobes", 32'(obs), 32'(0));

        // Randomized instruction stream (HALT excluded).
        for (int i = 0; i < 200; i++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 14));
            run_instr(w, int'($urandom_range(0, WL + 1)), 16'($urandom));
        end

`ifdef CTRL_HALT_EN
        i_bus = 16'hF000;
        #1;
        check("halt_fetch", 32'(obs), 32'(0));
        next_cycle();
        check("halt_exec", 32'(obs), 32'(0));
        for (int i = 0; i < 22; i++) begin
            next_cycle();
            i_bus = 16'($urandom); mem_ready = 1'($urandom);
            #1;
            check("halted_flag", 32'(halted), 32'(1));
            check("halted_strobes", 32'(obs), 32'(0));
        end
`else
        run_instr(16'hF000, 0, 16'h0000);
        #1;
        check("nohalt_fetch", 32'(obs), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
